// File: rtl/div_pkg.sv
//------------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the divide-ratio scheduler: FSM state encoding,
//   legal ratio limits and the ratio type.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package div_pkg;

  // Legal divide ratios (inclusive)
  localparam int N_MIN = 2;
  localparam int N_MAX = 15;

  // Narrowest field that can hold every legal ratio
  localparam int RATIO_W = $clog2(N_MAX + 1);

  typedef logic [RATIO_W-1:0] ratio_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
//------------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin arbiter with a registered priority pointer.
//   Ports:
//     clk      - clock
//     reset    - synchronous active-low reset (pointer -> requester 0)
//     req      - request vector, bit i = requester i
//     en       - grant enable; grant is forced to 0 when low
//     advance  - a granted transfer happened this cycle; move the pointer
//     grant    - one-hot grant (or 0)
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       advance,
  output logic [1:0] grant
);

  // ptr_q = index of the requester that wins a tie
  logic ptr_q;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        grant = ptr_q ? 2'b10 : 2'b01;
      end else begin
        grant = req;
      end
    end
  end

  // After a transfer, favour whichever requester did not just win
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else if (advance) begin
      ptr_q <= grant[0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/div_sched.sv
//------------------------------------------------------------------------------
// div_sched
//   Clock-divider ratio scheduler. Two requesters may ask for a new divide
//   ratio; requests are arbitrated round-robin, and an accepted ratio is only
//   applied at the end of the current output period so the divider never sees
//   a truncated period.
//   Ports:
//     clk          - clock
//     reset        - synchronous active-low reset
//     req_valid    - per-requester ratio-change request
//     req_n0/1     - ratio requested by requester 0/1
//     req_ready    - one-hot grant, transfer on valid & ready
//     n_out        - ratio currently driven to the divider
//     div_rst      - one-cycle pulse when n_out changes
//     period_tick  - high in the last cycle of each output period
//     busy         - high while a ratio change is in flight
//     err          - one-cycle pulse after an accepted illegal ratio
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module div_sched
  import div_pkg::*;
#(
  parameter int                 N_WIDTH   = 4,
  parameter logic [N_WIDTH-1:0] N_DEFAULT = 4'd2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  input  logic [N_WIDTH-1:0] req_n0,
  input  logic [N_WIDTH-1:0] req_n1,
  output logic [1:0]         req_ready,
  output logic [N_WIDTH-1:0] n_out,
  output logic               div_rst,
  output logic               period_tick,
  output logic               busy,
  output logic               err
);

  state_t             state_q, state_d;
  logic [N_WIDTH-1:0] n_out_q;
  logic [N_WIDTH-1:0] cnt_q;
  logic [N_WIDTH-1:0] pending_q;
  logic [N_WIDTH-1:0] sel_n;
  logic               err_q;
  logic               tick;
  logic               xfer;
  logic               legal;
  logic               arb_en;
  logic [1:0]         grant;

  assign tick = (cnt_q == n_out_q - N_WIDTH'(1));

  // Grants are only offered in IDLE and never while reset is held
  assign arb_en = reset && (state_q == IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .en      (arb_en),
    .advance (xfer),
    .grant   (grant)
  );

  assign xfer  = |(req_valid & grant);
  assign sel_n = grant[1] ? req_n1 : req_n0;
  assign legal = (sel_n >= N_WIDTH'(N_MIN));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // Equal ratio is accepted but needs no change; illegal is dropped
        if (xfer && legal && (sel_n != n_out_q)) begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (tick) begin
          state_d = APPLY;
        end
      end
      APPLY: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      n_out_q   <= N_DEFAULT;
      cnt_q     <= '0;
      pending_q <= N_DEFAULT;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= xfer && !legal;
      if ((state_q == IDLE) && (state_d == PEND)) begin
        pending_q <= sel_n;
      end
      // APPLY is only entered on a period boundary, so restarting the
      // counter here coincides with its natural wrap
      if (state_d == APPLY) begin
        n_out_q <= pending_q;
        cnt_q   <= '0;
      end else if (tick) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + N_WIDTH'(1);
      end
    end
  end

  // Status outputs are held low for the whole time reset is asserted
  assign req_ready   = grant;
  assign n_out       = n_out_q;
  assign period_tick = tick;
  assign busy        = reset && (state_q != IDLE);
  assign div_rst     = reset && (state_q == APPLY);
  assign err         = reset && err_q;

endmodule

`default_nettype wire
